// File: rtl/bias_accum_pkg.sv
// Shared constants, FSM state type and saturation helper for the bias/accumulate/ReLU stage.
package bias_accum_pkg;

  localparam int unsigned DATA_W = 18;
  localparam logic [DATA_W-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 18'h20000;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Callers sign-extend their wide sum into 64 bits before calling.
  function automatic logic [DATA_W-1:0] sat_to_data(input logic signed [63:0] v);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = 64'sd131071;
    lo = -64'sd131072;
    if (v > hi)
      return SAT_MAX;
    else if (v < lo)
      return SAT_MIN;
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/bias_sat_relu.sv
// One lane: adds accumulator, final partial sum and bias, saturates to DATA_W, optional ReLU.
module bias_sat_relu
  import bias_accum_pkg::*;
#(
  parameter int ACC_W = 21
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] psum,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     relu_en,
  output logic        [DATA_W-1:0] res
);

  logic signed [ACC_W:0]    sum;
  logic        [DATA_W-1:0] sat;

  always_comb begin
    sum = (ACC_W+1)'(acc) + (ACC_W+1)'(psum) + (ACC_W+1)'(bias);
    sat = sat_to_data(64'(sum));
    res = (relu_en && sat[DATA_W-1]) ? '0 : sat;
  end

endmodule

// File: rtl/bias_accum_relu.sv
// Per-lane partial-sum accumulator over N_PASS beats; final beat adds bias, saturates,
// applies ReLU and holds one registered output word until the downstream handshake.
module bias_accum_relu
  import bias_accum_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int N_PASS       = 4,
  parameter int ACC_W        = DATA_W + $clog2(N_PASS) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_adder_tree*DATA_W-1:0] bias_i,
  input  logic [N_adder_tree*DATA_W-1:0] psum_i,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           relu_en,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0]                    tile_cnt
);

  localparam int PCW = (N_PASS > 1) ? $clog2(N_PASS) : 1;

  if (ACC_W < DATA_W + $clog2(N_PASS) + 1) begin : g_acc_w_check
    $error("ACC_W too small for N_PASS accumulation");
  end
  if (N_PASS < 1) begin : g_npass_check
    $error("N_PASS must be at least 1");
  end

  state_t state_q, state_d;
  logic [PCW-1:0] pass_cnt;
  logic signed [ACC_W-1:0] acc [N_adder_tree];
  logic [DATA_W-1:0] lane_res [N_adder_tree];
  logic beat, last_beat, handshake;

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == S_ACC);
    beat      = in_valid && in_ready;
    last_beat = beat && (pass_cnt == PCW'(N_PASS - 1));
    handshake = (state_q == S_OUT) && out_ready;
    if (last_beat)
      state_d = S_OUT;
    else if (handshake)
      state_d = S_ACC;
  end

  assign out_valid = (state_q == S_OUT);

  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    logic signed [ACC_W-1:0] acc_in;
    // A final beat with pass_cnt==0 only occurs when N_PASS==1; the stale acc must not leak in.
    assign acc_in = (N_PASS > 1) ? acc[g] : '0;
    bias_sat_relu #(.ACC_W(ACC_W)) u_lane (
      .acc     (acc_in),
      .psum    (psum_i[g*DATA_W +: DATA_W]),
      .bias    (bias_i[g*DATA_W +: DATA_W]),
      .relu_en (relu_en),
      .res     (lane_res[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ACC;
      pass_cnt <= '0;
      out_data <= '0;
      tile_cnt <= '0;
      for (int unsigned i = 0; i < N_adder_tree; i++)
        acc[i] <= '0;
    end else begin
      state_q <= state_d;
      if (beat) begin
        pass_cnt <= last_beat ? '0 : pass_cnt + 1'b1;
        for (int unsigned i = 0; i < N_adder_tree; i++) begin
          if (pass_cnt == '0)
            acc[i] <= ACC_W'($signed(psum_i[i*DATA_W +: DATA_W]));
          else
            acc[i] <= acc[i] + ACC_W'($signed(psum_i[i*DATA_W +: DATA_W]));
        end
      end
      if (last_beat) begin
        for (int unsigned i = 0; i < N_adder_tree; i++)
          out_data[i*DATA_W +: DATA_W] <= lane_res[i];
      end
      if (handshake)
        tile_cnt <= tile_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bias_accum_relu.sv
// Self-checking bench for bias_accum_relu: vector table, random tiles vs integer model, corner sequences.
module tb_bias_accum_relu;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] bias_i, psum_i, out_data;
  logic         in_valid, in_ready, relu_en, out_valid, out_ready;
  logic [15:0]  tile_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_tiles = 0;

  bias_accum_relu #(.N_adder_tree(N), .N_PASS(4)) dut (
    .clk(clk), .rst(rst), .bias_i(bias_i), .psum_i(psum_i),
    .in_valid(in_valid), .in_ready(in_ready), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][W-1:0] ps;
    logic [W-1:0]      bias;
    logic              relu;
    logic [W-1:0]      exp;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [W-1:0] splat(input logic [DW-1:0] v);
    logic [W-1:0] r;
    for (int l = 0; l < N; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  // Integer reference: sum of beats plus bias, clamp to 18-bit signed, optional ReLU.
  function automatic logic [W-1:0] model(input logic [3:0][W-1:0] ps, input logic [W-1:0] b,
                                         input logic relu);
    logic [W-1:0] r;
    for (int l = 0; l < N; l++) begin
      int s;
      s = int'($signed(b[l*DW +: DW]));
      for (int k = 0; k < 4; k++) s += int'($signed(ps[k][l*DW +: DW]));
      if (s > 131071) s = 131071;
      if (s < -131072) s = -131072;
      if (relu && s < 0) s = 0;
      r[l*DW +: DW] = DW'(s);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Four back-to-back beats; bias and relu_en are perturbed on non-final beats since only the final beat counts.
  task automatic send_tile(input logic [3:0][W-1:0] ps, input logic [W-1:0] b, input logic relu);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("out_valid_low_during_tile", W'(out_valid), W'(0));
      in_valid = 1'b1;
      psum_i   = ps[k];
      bias_i   = (k == 3) ? b : W'({$urandom, $urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom});
      relu_en  = (k == 3) ? relu : ~relu;
    end
    @(negedge clk);
    in_valid = 1'b0;
    relu_en  = ~relu;
  endtask

  task automatic finish_tile(input string name, input logic [W-1:0] exp);
    check({name, "_valid"}, W'(out_valid), W'(1));
    check({name, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_tiles++;
    check({name, "_tile_cnt"}, W'(tile_cnt), W'(exp_tiles));
    check({name, "_valid_drop"}, W'(out_valid), W'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_tiles = 0;
  endtask

  initial begin
    logic [3:0][W-1:0] ps;
    logic [W-1:0] hold;
    int beats_at[4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; relu_en = 1'b0;
    psum_i = '0; bias_i = '0;
    @(negedge clk); @(negedge clk);
    check("reset_out_data", out_data, '0);
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_tile_cnt", W'(tile_cnt), W'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", W'(in_ready), W'(1));

    // Directed table entries with hand-derived expectations
    for (int k = 0; k < 4; k++) ps[k] = splat(18'd100);
    vecs[0] = '{ps: ps, bias: splat(18'b111111110010000000), relu: 1'b0, exp: splat(18'h3FE10)};
    vecs[1] = '{ps: ps, bias: splat(18'b111111110010000000), relu: 1'b1, exp: '0};
    for (int k = 0; k < 4; k++) ps[k] = splat(18'h1FFFF);
    vecs[2] = '{ps: ps, bias: splat(18'd1000), relu: 1'b0, exp: splat(18'h1FFFF)};
    for (int k = 0; k < 4; k++) ps[k] = splat(18'h20000);
    vecs[3] = '{ps: ps, bias: splat(18'h3FFFF), relu: 1'b0, exp: splat(18'h20000)};
    ps = '0;
    ps[0][0 +: DW] = 18'd10;  ps[1][0 +: DW] = -18'sd20;
    ps[2][0 +: DW] = 18'd30;  ps[3][0 +: DW] = -18'sd40;
    ps[0][15*DW +: DW] = 18'd1; ps[1][15*DW +: DW] = 18'd2;
    ps[2][15*DW +: DW] = 18'd3; ps[3][15*DW +: DW] = 18'd4;
    vecs[4].ps = ps;
    vecs[4].bias = '0;
    vecs[4].bias[0 +: DW] = 18'd5;
    vecs[4].bias[15*DW +: DW] = 18'd1460;
    vecs[4].relu = 1'b0;
    vecs[4].exp = '0;
    vecs[4].exp[0 +: DW] = 18'h3FFF1;
    vecs[4].exp[15*DW +: DW] = 18'd1470;
    // Random entries: expectations from the integer model
    for (int v = 5; v < 13; v++) begin
      for (int k = 0; k < 4; k++)
        for (int l = 0; l < N; l++) ps[k][l*DW +: DW] = DW'($urandom);
      vecs[v].ps = ps;
      for (int l = 0; l < N; l++) vecs[v].bias[l*DW +: DW] = DW'($urandom);
      vecs[v].relu = 1'($urandom);
      vecs[v].exp = model(vecs[v].ps, vecs[v].bias, vecs[v].relu);
    end

    for (int v = 0; v < 13; v++) begin
      send_tile(vecs[v].ps, vecs[v].bias, vecs[v].relu);
      finish_tile($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Backpressure: held output, ignored beats, then a clean tile
    for (int k = 0; k < 4; k++) ps[k] = splat(18'd7);
    send_tile(ps, '0, 1'b0);
    hold = out_data;
    check("bp_first_data", out_data, splat(18'd28));
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      psum_i = W'({$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_valid_held", W'(out_valid), W'(1));
      check("bp_data_held", out_data, hold);
    end
    in_valid = 1'b0;
    finish_tile("bp_release", splat(18'd28));
    for (int k = 0; k < 4; k++) ps[k] = splat(18'd1);
    send_tile(ps, '0, 1'b0);
    finish_tile("bp_next_tile", splat(18'd4));

    // Sparse in_valid: beats on cycles 0,3,5,9 of a 10-cycle window
    beats_at = '{0, 3, 5, 9};
    bias_i = splat(18'd3);
    relu_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("gap_no_early_valid", W'(out_valid), W'(0));
      in_valid = (c == beats_at[0] || c == beats_at[1] || c == beats_at[2] || c == beats_at[3]);
      psum_i = in_valid ? splat(18'd25) : W'({$urandom, $urandom, $urandom, $urandom, $urandom,
                                              $urandom, $urandom, $urandom, $urandom});
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_tile("gap_tile", splat(18'd103));

    // Reset mid-tile discards the partial accumulation
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; psum_i = splat(18'd500);
    end
    do_reset();
    check("rst_mid_valid", W'(out_valid), W'(0));
    check("rst_mid_tile_cnt", W'(tile_cnt), W'(0));
    for (int k = 0; k < 4; k++) ps[k] = splat(18'd100);
    send_tile(ps, '0, 1'b0);
    finish_tile("rst_mid_after", splat(18'd400));

    // Reset while an output is pending
    send_tile(ps, splat(18'd9), 1'b0);
    check("rst_pend_valid_before", W'(out_valid), W'(1));
    do_reset();
    check("rst_pend_valid", W'(out_valid), W'(0));
    check("rst_pend_tile_cnt", W'(tile_cnt), W'(0));
    send_tile(ps, '0, 1'b0);
    finish_tile("rst_pend_after", splat(18'd400));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/bias_accum_relu.md
Name: bias_accum_relu

Overview:
- Consumer of the per-layer bias bus: N_adder_tree lanes of 18-bit signed constants, lane i at bits [18*(i+1)-1 : 18*i].
- Accumulates adder-tree partial sums per lane over N_PASS input-channel passes.
- On the final pass, adds the lane bias, saturates to 18 bits, applies optional ReLU and presents one registered output word per tile with a valid/ready handshake.
- Sits between each layer's adder-tree array and the output feature-map writer.

Parameters:
- N_adder_tree, 16, number of parallel lanes.
- N_PASS, 4, accepted input beats per output tile (>=1).
- DATA_W, 18, lane width of psum_i, bias_i and out_data (signed two's complement, same fixed-point scale on all three).
- ACC_W, DATA_W+$clog2(N_PASS)+1, internal accumulator width; elaboration error if smaller.

Ports:
- clk  input  1  clock (only clock)
- rst  input  1  synchronous, active-high reset
- bias_i  input  N_adder_tree*18  per-lane bias, static during operation
- psum_i  input  N_adder_tree*18  per-lane partial sums from the adder trees
- in_valid  input  1  psum_i beat valid
- in_ready  output  1  block accepts a beat
- relu_en  input  1  1 = clamp negative results to 0; sampled on the final beat
- out_data  output  N_adder_tree*18  biased, saturated, activated result
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- tile_cnt  output  16  completed output handshakes, wraps 0xFFFF->0

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State S_ACC; pass_cnt=0; all accumulators 0.
  - out_valid=0, out_data=0, tile_cnt=0.
  - Reset overrides everything, including a tile in progress or a pending output; the partial tile is discarded.
- FSM S_ACC:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready.
  - pass_cnt==0: acc[i] = sext(psum[i]); otherwise acc[i] += sext(psum[i]).
  - pass_cnt increments per accepted beat only; idle cycles (in_valid=0) change nothing.
- Final beat (accepted with pass_cnt==N_PASS-1):
  - sum[i] = acc_prev[i] + sext(psum[i]) + sext(bias[i]) at ACC_W+1 bits; acc_prev is ignored when N_PASS==1.
  - Saturate to [-131072, +131071].
  - If relu_en, negative results become 0.
  - Result registered into out_data; out_valid=1 on the next cycle (latency 1 from final beat); pass_cnt=0; go to S_OUT.
- FSM S_OUT:
  - in_ready=0; in_valid beats are ignored and not counted.
  - out_data and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready: out_valid=0, tile_cnt+=1, return to S_ACC. The next beat can be accepted the following cycle.
  - out_data keeps its last value after the handshake; it is don't-care while out_valid=0.
- Bias handling:
  - bias_i is used only at the final beat; it is never accumulated.
  - bias_i changes mid-tile are legal and take effect at the final beat.
- Accumulator overflow is impossible by ACC_W sizing; only the final result saturates.
- N_PASS==1: every accepted beat is a final beat.

Decomposition:
- Package bias_accum_pkg:
  - DATA_W, SAT_MAX=18'h1FFFF, SAT_MIN=18'h20000.
  - State enum {S_ACC, S_OUT}.
  - Function sat_to_data(signed wide).
- Sub-module bias_sat_relu (one per lane via generate):
  - Combinational add of acc + psum + bias, saturate, ReLU.
  - Top level owns the FSM, counters and registers.

Test Plan:
- N_PASS=4, all lanes psum=100 x4 beats, bias=-896 (18'b111111110010000000), relu_en=0 -> out_valid 1 cycle after 4th beat, every lane = -496 (18'h3FE10); relu_en=1 -> every lane 0.
- psum=+131071 x4, bias=+1000 -> every lane 18'h1FFFF; psum=-131072 x4, bias=-1 -> every lane 18'h20000.
- Mixed lanes: lane0 psum {10,-20,30,-40}, bias +5 -> -15 (18'h3FFF1); lane15 psum {1,2,3,4}, bias +1460 -> 1470.
- Backpressure:
  - out_ready=0 for 5 cycles with in_valid=1 and varying psum -> out_valid, out_data stable, in_ready=0.
  - On out_ready=1 -> tile_cnt 0->1.
  - Next tile of psum=1 x4, bias 0 -> 4 (earlier ignored beats have no effect).
- In_valid gaps: 4 beats spread over 10 cycles -> exactly one output, latency 1 after 4th accepted beat.
- Reset mid-tile after 2 beats of 500, and reset while out_valid=1 -> out_valid=0, tile_cnt=0; next 4 beats of 100 with bias 0 -> 400, with no residue from pre-reset beats.
